// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_t          : sequencer state encoding (matches the seq_state output)
//   DEF_*                : default parameter values for reset_sequencer
//   cnt_width()          : counter width able to hold 0..max_val without wrapping
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        PERIPH_UP = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_HOLD_CYCLES     = 1024;
    localparam int unsigned DEF_CORE_DELAY      = 64;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   sys_clock : destination clock
//   reset     : asynchronous active-low clear (output reads 0 while held)
//   d         : asynchronous input level
//   q         : level synchronized to sys_clock, two edges of latency
module sync_2ff (
    input  logic sys_clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer between the PLL and the SoC top. Holds peripherals and core
// in reset until the PLL has been locked for HOLD_CYCLES, releases the
// peripherals, then releases the core CORE_DELAY cycles later. Lock loss or a
// debounced button press sends it back to WAIT_LOCK.
//   sys_clock    : PLL output clock, the only clock
//   reset        : asynchronous active-low reset
//   pll_locked   : PLL lock, asynchronous
//   rst_btn      : raw board button, active-high, bouncing
//   periph_reset : active-high peripheral reset
//   core_reset   : active-high core reset
//   seq_state    : current state encoding
//   reset_count  : saturating count of warm re-entries to WAIT_LOCK
//
// state     | meaning
// ----------+---------------------------------------------------
// WAIT_LOCK | both resets held, waiting for lock and idle button
// HOLD      | locked, both resets held for HOLD_CYCLES
// PERIPH_UP | peripherals released, core held for CORE_DELAY
// RUN       | both resets released
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned CORE_DELAY      = DEF_CORE_DELAY
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       rst_btn,
    output logic       periph_reset,
    output logic       core_reset,
    output logic [1:0] seq_state,
    output logic [7:0] reset_count
);

    localparam int unsigned SEQ_MAX = (HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY;
    localparam int unsigned SEQ_W   = cnt_width(SEQ_MAX);
    localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES);

    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] CORE_LAST = SEQ_W'(CORE_DELAY - 1);
    localparam logic [SEQ_W-1:0] SEQ_TOP   = SEQ_W'(SEQ_MAX);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic             lock_s;
    logic             btn_s;
    logic             btn_db;
    logic [DB_W-1:0]  db_cnt;
    logic [SEQ_W-1:0] seq_cnt;
    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             abort;
    logic             warm_entry;

    sync_2ff u_sync_lock (
        .sys_clock (sys_clock),
        .reset     (reset),
        .d         (pll_locked),
        .q         (lock_s)
    );

    sync_2ff u_sync_btn (
        .sys_clock (sys_clock),
        .reset     (reset),
        .d         (rst_btn),
        .q         (btn_s)
    );

    // Debounce: btn_db follows btn_s only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; a single agreeing sample restarts the count.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Abort has priority over counter expiry so a lock loss coinciding with
    // the end of HOLD/PERIPH_UP never releases a reset.
    always_comb begin
        state_d = state_q;
        abort   = !lock_s || btn_db;
        case (state_q)
            WAIT_LOCK: if (lock_s && !btn_db) state_d = HOLD;
            HOLD: begin
                if (abort)                     state_d = WAIT_LOCK;
                else if (seq_cnt == HOLD_LAST) state_d = PERIPH_UP;
            end
            PERIPH_UP: begin
                if (abort)                     state_d = WAIT_LOCK;
                else if (seq_cnt == CORE_LAST) state_d = RUN;
            end
            RUN:     if (abort) state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign warm_entry = (state_q != WAIT_LOCK) && (state_d == WAIT_LOCK);

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_LOCK;
            seq_cnt     <= '0;
            reset_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                seq_cnt <= '0;
            end else if (seq_cnt != SEQ_TOP) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (warm_entry && (reset_count != 8'hFF)) begin
                reset_count <= reset_count + 8'd1;
            end
        end
    end

    // Pure decode of the state register: the async clear of state_q asserts
    // both resets immediately, with no path from any input.
    assign periph_reset = (state_q == WAIT_LOCK) || (state_q == HOLD);
    assign core_reset   = (state_q != RUN);
    assign seq_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       sys_clock;
    logic       reset;
    logic       pll_locked;
    logic       rst_btn;
    logic       periph_reset;
    logic       core_reset;
    logic [1:0] seq_state;
    logic [7:0] reset_count;

    int checks   = 0;
    int failures = 0;

    reset_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .CORE_DELAY      (4)
    ) dut (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .rst_btn      (rst_btn),
        .periph_reset (periph_reset),
        .core_reset   (core_reset),
        .seq_state    (seq_state),
        .reset_count  (reset_count)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic       lock;
        logic       btn;
        int         n;
        logic [1:0] st;
        logic       p;
        logic       c;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[23];

    task automatic step(input int n);
        repeat (n) @(posedge sys_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] es, input logic ep,
                         input logic ec, input logic [7:0] ecnt);
        checks++;
        if (seq_state !== es || periph_reset !== ep || core_reset !== ec || reset_count !== ecnt) begin
            failures++;
            $display("FAIL %s: got state=%0d periph=%0b core=%0b count=%0d, want state=%0d periph=%0b core=%0b count=%0d",
                     name, seq_state, periph_reset, core_reset, reset_count, es, ep, ec, ecnt);
        end
    endtask

    // Expected reset levels follow from the state: periph held in states 0/1,
    // core held in every state but 3.
    task automatic check_st(input string name, input logic [1:0] es, input logic [7:0] ecnt);
        check(name, es, (es == 2'd0) || (es == 2'd1), es != 2'd3, ecnt);
    endtask

    initial begin
        // lock, btn, edges, state, periph, core, count
        vecs[0]  = '{1'b1, 1'b0, 2, 2'd0, 1'b1, 1'b1, 8'd0};  // lock still in synchronizer
        vecs[1]  = '{1'b1, 1'b0, 1, 2'd1, 1'b1, 1'b1, 8'd0};  // edge 3: HOLD
        vecs[2]  = '{1'b1, 1'b0, 7, 2'd1, 1'b1, 1'b1, 8'd0};  // edge 10
        vecs[3]  = '{1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b1, 8'd0};  // edge 11: periph falls
        vecs[4]  = '{1'b1, 1'b0, 3, 2'd2, 1'b0, 1'b1, 8'd0};  // edge 14
        vecs[5]  = '{1'b1, 1'b0, 1, 2'd3, 1'b0, 1'b0, 8'd0};  // edge 15: core falls
        vecs[6]  = '{1'b1, 1'b0, 5, 2'd3, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 2, 2'd3, 1'b0, 1'b0, 8'd0};  // lock loss in synchronizer
        vecs[8]  = '{1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b1, 8'd1};  // 3rd edge: WAIT_LOCK
        vecs[9]  = '{1'b1, 1'b0, 2, 2'd0, 1'b1, 1'b1, 8'd1};  // relock
        vecs[10] = '{1'b1, 1'b0, 1, 2'd1, 1'b1, 1'b1, 8'd1};
        vecs[11] = '{1'b1, 1'b0, 7, 2'd1, 1'b1, 1'b1, 8'd1};
        vecs[12] = '{1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b1, 8'd1};
        vecs[13] = '{1'b1, 1'b0, 3, 2'd2, 1'b0, 1'b1, 8'd1};
        vecs[14] = '{1'b1, 1'b0, 1, 2'd3, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{1'b0, 1'b0, 3, 2'd0, 1'b1, 1'b1, 8'd2};
        vecs[16] = '{1'b1, 1'b0, 3, 2'd1, 1'b1, 1'b1, 8'd2};  // HOLD entered at E
        vecs[17] = '{1'b1, 1'b0, 5, 2'd1, 1'b1, 1'b1, 8'd2};  // E+5
        vecs[18] = '{1'b0, 1'b0, 2, 2'd1, 1'b1, 1'b1, 8'd2};  // E+7
        vecs[19] = '{1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b1, 8'd3};  // E+8: abort beats expiry
        vecs[20] = '{1'b1, 1'b0, 3, 2'd1, 1'b1, 1'b1, 8'd3};
        vecs[21] = '{1'b1, 1'b0, 8, 2'd2, 1'b0, 1'b1, 8'd3};
        vecs[22] = '{1'b1, 1'b0, 4, 2'd3, 1'b0, 1'b0, 8'd3};

        reset      = 1'b0;
        pll_locked = 1'b0;
        rst_btn    = 1'b0;
        step(3);
        check("reset_state", 2'd0, 1'b1, 1'b1, 8'd0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            pll_locked = vecs[i].lock;
            rst_btn    = vecs[i].btn;
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].p, vecs[i].c, vecs[i].cnt);
        end

        // Bounces shorter than the debounce window must be ignored.
        for (int b = 0; b < 5; b++) begin
            rst_btn = 1'b1;
            step(3);
            check_st($sformatf("bounce_hi%0d", b), 2'd3, 8'd3);
            rst_btn = 1'b0;
            step(3);
            check_st($sformatf("bounce_lo%0d", b), 2'd3, 8'd3);
        end
        step(6);
        check_st("bounce_settle", 2'd3, 8'd3);

        // Real press: 2 sync + 4 debounce + 1 FSM edge.
        rst_btn = 1'b1;
        step(6);
        check_st("press_edge6", 2'd3, 8'd3);
        step(1);
        check_st("press_edge7", 2'd0, 8'd4);
        step(13);
        check_st("press_held", 2'd0, 8'd4);
        rst_btn = 1'b0;
        step(6);
        check_st("release_edge6", 2'd0, 8'd4);
        step(1);
        check_st("release_edge7", 2'd1, 8'd4);
        step(8);
        check_st("release_periph", 2'd2, 8'd4);

        // Async reset between edges, mid PERIPH_UP.
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 2'd0, 1'b1, 1'b1, 8'd0);
        #2;
        reset = 1'b1;
        step(2);
        check_st("post_reset_wait", 2'd0, 8'd0);
        step(1);
        check_st("post_reset_hold", 2'd1, 8'd0);

        // Saturation of reset_count over 300 lock-loss events.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(3);
            if (i == 0 || i == 254 || i == 255 || i == 299)
                check_st($sformatf("sat_event%0d", i + 1), 2'd0, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            pll_locked = 1'b1;
            step(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
